// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller: control-field bit
// positions, FSM state encoding and default widths.
package mem_stage_ctrl_pkg;

  // Default MSB indices (data word is 16 bits, control field is 3 bits)
  localparam int DATA_MSB    = 15;
  localparam int CTRL_MSB    = 2;
  localparam int TMO_DEFAULT = 15;

  // Bit positions inside the EX/MEM control field
  localparam int CTRL_RD   = 0;
  localparam int CTRL_WR   = 1;
  localparam int CTRL_BYTE = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // True when the control field requests a data-memory access
  function automatic logic is_mem_op(input logic [CTRL_MSB:0] ctrl);
    return ctrl[CTRL_RD] | ctrl[CTRL_WR];
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Bundle of the EX/MEM inputs, data-memory handshake, stall and MEM/WB
// outputs. master = the controller, slave = pipeline/memory surroundings.
interface mem_stage_ctrl_if
  import mem_stage_ctrl_pkg::*;
#(
  parameter int S = DATA_MSB,
  parameter int C = CTRL_MSB
);
  // EX/MEM register outputs
  logic [S:0] ex_upper;
  logic [S:0] ex_lower;
  logic [S:0] ex_word;
  logic [7:0] ex_byte;
  logic [C:0] ex_ctrl;
  // Data-memory handshake
  logic       mem_req;
  logic       mem_we;
  logic [S:0] mem_addr;
  logic [S:0] mem_wdata;
  logic [1:0] mem_be;
  logic       mem_ack;
  logic [S:0] mem_rdata;
  // Pipeline control and MEM/WB outputs
  logic       stall;
  logic [S:0] wb_upper;
  logic [S:0] wb_data;
  logic [C:0] wb_ctrl;
  logic       wb_valid;
  logic       err;

  modport master (
    input  ex_upper, ex_lower, ex_word, ex_byte, ex_ctrl, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output stall, wb_upper, wb_data, wb_ctrl, wb_valid, err
  );

  modport slave (
    output ex_upper, ex_lower, ex_word, ex_byte, ex_ctrl, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  stall, wb_upper, wb_data, wb_ctrl, wb_valid, err
  );

endinterface

// File: rtl/mem_stage_ctrl_byte_lane.sv
// Combinational byte-lane logic: store data/byte-enable steering and load
// byte extraction with zero extension, keyed on address bit 0 and byte mode.
module mem_stage_ctrl_byte_lane
  import mem_stage_ctrl_pkg::*;
#(
  parameter int S = DATA_MSB
) (
  input  logic       i_byte_mode,
  input  logic       i_addr0,
  input  logic [S:0] i_st_word,
  input  logic [7:0] i_st_byte,
  output logic [S:0] o_st_wdata,
  output logic [1:0] o_st_be,
  input  logic       i_ld_byte_mode,
  input  logic       i_ld_addr0,
  input  logic [S:0] i_ld_rdata,
  output logic [S:0] o_ld_data
);

  logic [7:0] w_ld_byte;

  // Byte stores replicate the byte on both lanes; the enable picks the lane
  // (odd address = high lane).
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign o_st_wdata[gi*8 +: 8] = i_byte_mode ? i_st_byte : i_st_word[gi*8 +: 8];
    assign o_st_be[gi]           = !i_byte_mode || (i_addr0 == 1'(gi));
  end

  if (S > 15) begin : g_upper
    assign o_st_wdata[S:16] = i_st_word[S:16];
  end

  // Byte loads take the addressed lane and zero-extend it
  assign w_ld_byte = i_ld_addr0 ? i_ld_rdata[15:8] : i_ld_rdata[7:0];
  assign o_ld_data = i_ld_byte_mode ? {{(S-7){1'b0}}, w_ld_byte} : i_ld_rdata;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: decodes the EX/MEM control field, runs a req/ack
// access to data memory while stalling upstream, and strobes the result
// into MEM/WB. Optional macro MEM_TIMEOUT_EN adds a BUSY timeout of TMO
// cycles that completes the op with zero data and sets err.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int S   = DATA_MSB,
  parameter int C   = CTRL_MSB,
  parameter int TMO = TMO_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  mem_stage_ctrl_if.master bus
);

  state_t     r_state;
  state_t     w_state_next;
  logic       w_mem_op;
  logic       w_stall;
  logic       w_accept;
  logic       w_complete;
  logic       w_timeout;
  logic       w_tmo_hit;

  logic       r_req;
  logic       r_we;
  logic [S:0] r_addr;
  logic [S:0] r_wdata;
  logic [1:0] r_be;
  logic [S:0] r_upper_lat;
  logic [S:0] r_lower_lat;
  logic [C:0] r_ctrl_lat;

  logic [S:0] r_wb_upper;
  logic [S:0] r_wb_data;
  logic [C:0] r_wb_ctrl;
  logic       r_wb_valid;
  logic       r_err;

  logic [S:0] w_st_wdata;
  logic [1:0] w_st_be;
  logic [S:0] w_ld_data;

  assign w_mem_op = is_mem_op(bus.ex_ctrl);

  // Store steering uses live EX/MEM inputs; load extraction uses latched op
  mem_stage_ctrl_byte_lane #(.S(S)) u_byte_lane (
    .i_byte_mode    (bus.ex_ctrl[CTRL_BYTE]),
    .i_addr0        (bus.ex_lower[0]),
    .i_st_word      (bus.ex_word),
    .i_st_byte      (bus.ex_byte),
    .o_st_wdata     (w_st_wdata),
    .o_st_be        (w_st_be),
    .i_ld_byte_mode (r_ctrl_lat[CTRL_BYTE]),
    .i_ld_addr0     (r_lower_lat[0]),
    .i_ld_rdata     (bus.mem_rdata),
    .o_ld_data      (w_ld_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  logic [CW-1:0] r_cnt;

  // Count BUSY cycles, restarting on each accepted op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_cnt <= '0;
    else if (w_accept)           r_cnt <= '0;
    else if (r_state == ST_BUSY) r_cnt <= r_cnt + 1'b1;
  end

  assign w_tmo_hit = (r_cnt == CNT_LAST);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next state, stall and event decode; ack beats a simultaneous timeout
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          w_stall      = 1'b1;
          w_accept     = 1'b1;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_stall = 1'b1;
        if (bus.mem_ack) begin
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Memory request registers and operand latches, held stable during BUSY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_upper_lat <= '0;
      r_lower_lat <= '0;
      r_ctrl_lat  <= '0;
    end else if (w_accept) begin
      r_req       <= 1'b1;
      r_we        <= bus.ex_ctrl[CTRL_WR];
      r_addr      <= {1'b0, bus.ex_lower[S:1]};
      r_wdata     <= bus.ex_ctrl[CTRL_WR] ? w_st_wdata : '0;
      r_be        <= bus.ex_ctrl[CTRL_WR] ? w_st_be : 2'b11;
      r_upper_lat <= bus.ex_upper;
      r_lower_lat <= bus.ex_lower;
      r_ctrl_lat  <= bus.ex_ctrl;
    end else if (w_complete || w_timeout) begin
      r_req <= 1'b0;
    end
  end

  // MEM/WB result registers with one-cycle valid strobe, plus sticky err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_upper <= '0;
      r_wb_data  <= '0;
      r_wb_ctrl  <= '0;
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_complete) begin
        r_wb_valid <= 1'b1;
        r_wb_upper <= r_upper_lat;
        r_wb_ctrl  <= r_ctrl_lat;
        r_wb_data  <= r_we ? r_lower_lat : w_ld_data;
      end else if (w_timeout) begin
        r_wb_valid <= 1'b1;
        r_wb_upper <= r_upper_lat;
        r_wb_ctrl  <= r_ctrl_lat;
        r_wb_data  <= '0;
      end else if (r_state == ST_IDLE && !w_mem_op && (bus.ex_ctrl != '0)) begin
        r_wb_valid <= 1'b1;
        r_wb_upper <= bus.ex_upper;
        r_wb_ctrl  <= bus.ex_ctrl;
        r_wb_data  <= bus.ex_lower;
      end
      if (w_accept && bus.ex_ctrl[CTRL_RD] && bus.ex_ctrl[CTRL_WR]) r_err <= 1'b1;
      if (r_state == ST_IDLE && bus.mem_ack)                        r_err <= 1'b1;
      if (w_timeout)                                                r_err <= 1'b1;
    end
  end

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;
  assign bus.stall     = w_stall;
  assign bus.wb_upper  = r_wb_upper;
  assign bus.wb_data   = r_wb_data;
  assign bus.wb_ctrl   = r_wb_ctrl;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: vector table of single ops plus hand-written
// sequences (read+write conflict, reset mid-access, spurious ack, long wait
// or timeout when MEM_TIMEOUT_EN is defined). Writeback results are checked
// against a scoreboard queue filled when each op is driven.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_TB = 4;
`else
  localparam int TMO_TB = 15;
`endif

  logic clk;
  logic rst;

  mem_stage_ctrl_if #(.S(15), .C(2)) bus ();

  mem_stage_ctrl #(.S(15), .C(2), .TMO(TMO_TB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [15:0] upper;
    logic [15:0] lower;
    logic [15:0] word;
    logic [7:0]  byt;
    int          delay;
    logic [15:0] rdata;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [1:0]  exp_be;
    logic [15:0] exp_wb;
  } vec_t;

  typedef struct {
    logic [15:0] upper;
    logic [15:0] data;
    logic [2:0]  ctrl;
  } wb_t;

  wb_t  sb_q[$];
  wb_t  mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] ctrl, input logic [15:0] upper,
                              input logic [15:0] lower, input logic [15:0] word,
                              input logic [7:0] byt, input int delay,
                              input logic [15:0] rdata, input logic exp_we,
                              input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                              input logic [1:0] exp_be, input logic [15:0] exp_wb);
    vec_t v;
    v.ctrl = ctrl; v.upper = upper; v.lower = lower; v.word = word; v.byt = byt;
    v.delay = delay; v.rdata = rdata; v.exp_we = exp_we; v.exp_addr = exp_addr;
    v.exp_wdata = exp_wdata; v.exp_be = exp_be; v.exp_wb = exp_wb;
    return v;
  endfunction

  task automatic push_exp(input logic [15:0] upper, input logic [15:0] data, input logic [2:0] ctrl);
    wb_t e;
    e.upper = upper; e.data = data; e.ctrl = ctrl;
    sb_q.push_back(e);
  endtask

  // Writeback monitor: every strobe must match the oldest expected result
  always @(posedge clk) begin
    #1;
    if (bus.wb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", bus.wb_valid, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wb_data",  bus.wb_data,  mon_e.data);
        chk("wb_upper", bus.wb_upper, mon_e.upper);
        chk("wb_ctrl",  bus.wb_ctrl,  mon_e.ctrl);
        $display("wb  upper=%h data=%h ctrl=%b", bus.wb_upper, bus.wb_data, bus.wb_ctrl);
      end
    end
  end

  task automatic run_op(input vec_t v);
    logic is_mem;
    int   stall_n;
    @(negedge clk);
    bus.ex_ctrl   = v.ctrl;
    bus.ex_upper  = v.upper;
    bus.ex_lower  = v.lower;
    bus.ex_word   = v.word;
    bus.ex_byte   = v.byt;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'(~v.rdata);
    #1;
    is_mem = v.ctrl[0] | v.ctrl[1];
    chk("stall_accept", bus.stall, is_mem);
    $display("op  ctrl=%b lower=%h delay=%0d", v.ctrl, v.lower, v.delay);
    if (!is_mem) begin
      if (v.ctrl != 3'b000) push_exp(v.upper, v.lower, v.ctrl);
      @(negedge clk);
      chk("nonmem_req", bus.mem_req, 1'b0);
      chk("nonmem_stall", bus.stall, 1'b0);
      bus.ex_ctrl = 3'b000;
    end else begin
      stall_n = 1;
      push_exp(v.upper, v.exp_wb, v.ctrl);
      for (int k = 0; k <= v.delay; k++) begin
        @(negedge clk);
        stall_n += int'(bus.stall);
        chk("mem_req",  bus.mem_req,  1'b1);
        chk("mem_we",   bus.mem_we,   v.exp_we);
        chk("mem_addr", bus.mem_addr, v.exp_addr);
        chk("mem_be",   bus.mem_be,   v.exp_be);
        if (v.exp_we) chk("mem_wdata", bus.mem_wdata, v.exp_wdata);
        if (k == 0) begin
          bus.ex_upper = 16'($urandom);
          bus.ex_lower = 16'($urandom);
          bus.ex_word  = 16'($urandom);
          bus.ex_byte  = 8'($urandom);
          bus.ex_ctrl  = 3'b100;
        end
        if (k == v.delay) begin
          bus.ex_ctrl   = 3'b000;
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = v.rdata;
        end
      end
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'($urandom);
      chk("req_drop",     bus.mem_req, 1'b0);
      chk("stall_drop",   bus.stall,   1'b0);
      chk("stall_cycles", stall_n,     v.delay + 2);
    end
  endtask

  int req_n;

  initial begin
    rst = 1'b0;
    bus.ex_ctrl = '0; bus.ex_upper = '0; bus.ex_lower = '0;
    bus.ex_word = '0; bus.ex_byte = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    //        ctrl    upper     lower     word      byte   dly rdata     we  addr      wdata     be     wb
    vecs[0] = mk(3'b100, 16'hCAFE, 16'h1234, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'b00, 16'h1234);
    vecs[1] = mk(3'b001, 16'h1111, 16'h0010, 16'h0000, 8'h00, 3, 16'hBEEF, 0, 16'h0008, 16'h0000, 2'b11, 16'hBEEF);
    vecs[2] = mk(3'b101, 16'h2222, 16'h0021, 16'h0000, 8'h00, 0, 16'hA55A, 0, 16'h0010, 16'h0000, 2'b11, 16'h00A5);
    vecs[3] = mk(3'b101, 16'h3333, 16'h0020, 16'h0000, 8'h00, 2, 16'hA55A, 0, 16'h0010, 16'h0000, 2'b11, 16'h005A);
    vecs[4] = mk(3'b110, 16'h4444, 16'h0003, 16'h0000, 8'h7E, 1, 16'h0000, 1, 16'h0001, 16'h7E7E, 2'b10, 16'h0003);
    vecs[5] = mk(3'b110, 16'h5555, 16'h0042, 16'hFFFF, 8'h3C, 0, 16'h0000, 1, 16'h0021, 16'h3C3C, 2'b01, 16'h0042);
    vecs[6] = mk(3'b010, 16'h6666, 16'h8000, 16'h1357, 8'h99, 0, 16'h0000, 1, 16'h4000, 16'h1357, 2'b11, 16'h8000);
    vecs[7] = mk(3'b100, 16'h7777, 16'hFFFF, 16'h0000, 8'h00, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'b00, 16'hFFFF);

    // Reset state
    #1;
    chk("rst_req",   bus.mem_req,  1'b0);
    chk("rst_stall", bus.stall,    1'b0);
    chk("rst_valid", bus.wb_valid, 1'b0);
    chk("rst_data",  bus.wb_data,  16'h0000);
    chk("rst_addr",  bus.mem_addr, 16'h0000);
    chk("rst_err",   bus.err,      1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_op(vecs[i]);
    chk("err_clean", bus.err, 1'b0);

    // Bubble cycles produce no writeback strobe (monitor flags any)
    @(negedge clk);
    bus.ex_ctrl = 3'b000; bus.ex_lower = 16'hDEAD;
    repeat (3) @(negedge clk);

    // Read and write both set: write wins, err goes sticky
    run_op(mk(3'b011, 16'h8888, 16'h0006, 16'hA1B2, 8'h00, 1, 16'h0000, 1, 16'h0003, 16'hA1B2, 2'b11, 16'h0006));
    chk("err_rdwr", bus.err, 1'b1);

    // Reset in BUSY aborts the access; a later spurious ack sets err
    @(negedge clk);
    bus.ex_ctrl = 3'b001; bus.ex_lower = 16'h0100;
    @(negedge clk);
    bus.ex_ctrl = 3'b000;
    chk("abort_req_before", bus.mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_req",   bus.mem_req, 1'b0);
    chk("abort_stall", bus.stall,   1'b0);
    chk("abort_err",   bus.err,     1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("spur_err", bus.err,     1'b1);
    chk("spur_req", bus.mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("err_cleared", bus.err, 1'b0);

    // Long wait without ack
    @(negedge clk);
    bus.ex_ctrl = 3'b001; bus.ex_lower = 16'h0044; bus.ex_upper = 16'h5A5A;
    @(negedge clk);
    bus.ex_ctrl = 3'b000;
    req_n = 0;
`ifdef MEM_TIMEOUT_EN
    push_exp(16'h5A5A, 16'h0000, 3'b001);
    for (int k = 0; k < 50; k++) begin
      if (bus.mem_req !== 1'b1) break;
      req_n++;
      @(negedge clk);
    end
    chk("tmo_cycles", req_n, TMO_TB);
    chk("tmo_req",    bus.mem_req, 1'b0);
    chk("tmo_err",    bus.err,     1'b1);
`else
    for (int k = 0; k < 40; k++) begin
      req_n += int'(bus.mem_req);
      @(negedge clk);
    end
    chk("wait_cycles", req_n, 40);
    push_exp(16'h5A5A, 16'h0F0F, 3'b001);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0F0F;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("wait_req", bus.mem_req, 1'b0);
    chk("wait_err", bus.err,     1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
